// File: rtl/ad7606_emu_pkg.sv
// Shared constants, state encoding and the oversampling-code helper for the
// AD7606B parallel-bus emulator.
package ad7606_emu_pkg;

    localparam int NUM_CH  = 8;
    localparam int OS_MAX  = 6;
    localparam int FRAME_W = 13;
    localparam int PTR_W   = 3;
    localparam int DATA_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // Codes above the deepest oversampling ratio behave as no oversampling.
    function automatic logic [2:0] os_eff(input logic [2:0] os);
        return (int'(os) > OS_MAX) ? 3'd0 : os;
    endfunction

endpackage

// File: rtl/ad7606_emu_sync.sv
// N-bit multi-stage flip-flop synchroniser with synchronous clear, used on
// every asynchronous control input of the emulator.
module ad7606_emu_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/ad7606_emulator.sv
// Behavioural stand-in for the converter side of an AD7606B parallel bus:
// CONVST start detection, BUSY timing, frame snapshot and CS/RD read-out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a rising edge of (convst_a & convst_b)
// ST_CONV | conversion running, busy timer counting down to 1
module ad7606_emulator
    import ad7606_emu_pkg::*;
#(
    parameter int FPGA_CLOCK_FREQ = 100,
    parameter int T_CONV_NS       = 4000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              adc_reset,
    input  logic              adc_convst_a,
    input  logic              adc_convst_b,
    input  logic [2:0]        adc_os,
    input  logic              adc_range,
    input  logic              adc_cs_n,
    input  logic              adc_rd_n,
    output logic              adc_busy,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_data_oe,
    output logic              adc_frstdata,
    output logic              conv_overrun
);

    localparam int BUSY_RAW    = FPGA_CLOCK_FREQ * T_CONV_NS / 1000;
    localparam int BUSY_CYCLES = (BUSY_RAW < 1) ? 1 : BUSY_RAW;
    localparam int CNT_W       = $clog2(BUSY_CYCLES * 64) + 1;

    logic [4:0]         w_sync_in;
    logic [4:0]         w_sync_out;
    logic               w_convst_a_s;
    logic               w_convst_b_s;
    logic               w_cs_n_s;
    logic               w_rd_n_s;
    logic               w_adc_reset_s;
    logic               w_clr;
    logic               w_conv_s;
    logic               w_start;
    logic               w_sel;
    logic               w_rd_rise;
    logic               w_load;
    logic               w_overrun;
    logic [CNT_W-1:0]   w_conv_len;
    state_t             w_state_nxt;
    logic               w_unused;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_conv_prev;
    logic               r_rd_prev;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [DATA_W-1:0]  r_shadow [NUM_CH];
    logic               r_busy;
    logic [DATA_W-1:0]  r_data;
    logic               r_data_oe;
    logic               r_frstdata;
    logic               r_overrun;

    // Range only changes the analogue front end of the real part.
    assign w_unused = &{1'b0, adc_range};

    assign w_sync_in = {adc_reset, adc_rd_n, adc_cs_n, adc_convst_b, adc_convst_a};

    ad7606_emu_sync #(
        .WIDTH  (5),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (sys_clk),
        .i_clear (rst),
        .i_d     (w_sync_in),
        .o_q     (w_sync_out)
    );

    assign w_convst_a_s  = w_sync_out[0];
    assign w_convst_b_s  = w_sync_out[1];
    assign w_cs_n_s      = w_sync_out[2];
    assign w_rd_n_s      = w_sync_out[3];
    assign w_adc_reset_s = w_sync_out[4];

    assign w_clr      = rst | w_adc_reset_s;
    assign w_conv_s   = w_convst_a_s & w_convst_b_s;
    assign w_start    = w_conv_s & ~r_conv_prev;
    assign w_sel      = ~w_cs_n_s;
    assign w_rd_rise  = w_rd_n_s & ~r_rd_prev;
    assign w_conv_len = CNT_W'(BUSY_CYCLES) << os_eff(adc_os);

    // Edge-detect history keeps tracking through a device reset so that a
    // level held across adc_reset does not look like a fresh edge afterwards.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_conv_prev <= 1'b0;
            r_rd_prev   <= 1'b0;
        end else begin
            r_conv_prev <= w_conv_s;
            r_rd_prev   <= w_rd_n_s;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_CONV;
                    w_load      = 1'b1;
                end
            end
            ST_CONV: begin
                w_overrun = w_start;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_clr) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= w_conv_len;
        end else if (r_state == ST_CONV) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Busy trails the state by one clock so it is high for exactly conv_len cycles.
    always_ff @(posedge sys_clk) begin
        if (w_clr) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (r_state == ST_CONV);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_clr) begin
            r_frame_cnt <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_shadow[n] <= '0;
            end
        end else if (w_load) begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            for (int n = 0; n < NUM_CH; n++) begin
                r_shadow[n] <= {PTR_W'(n), r_frame_cnt};
            end
        end
    end

    // A start event resets the pointer even if a read edge lands on the same clock.
    always_ff @(posedge sys_clk) begin
        if (w_clr) begin
            r_rd_ptr <= '0;
        end else if (w_load) begin
            r_rd_ptr <= '0;
        end else if (w_sel && w_rd_rise) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_clr) begin
            r_data_oe  <= 1'b0;
            r_data     <= '0;
            r_frstdata <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_data_oe  <= w_sel;
            r_data     <= w_sel ? r_shadow[r_rd_ptr] : '0;
            r_frstdata <= w_sel && (r_rd_ptr == '0);
            r_overrun  <= w_overrun;
        end
    end

    assign adc_busy     = r_busy;
    assign adc_data     = r_data;
    assign adc_data_oe  = r_data_oe;
    assign adc_frstdata = r_frstdata;
    assign conv_overrun = r_overrun;

endmodule
